pc_unit: RTL

Parametrised program-counter unit for the pipelined MIPS fetch stage, succeeding the single-mode relative-load PC. It selects among sequential, PC-relative branch, absolute jump/call and return targets. Redirects that arrive during a stall are held until fetch advances. An optional return-address stack (RAS) supplies return targets.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_if.sv | 28 ++
 rtl/pc_ras.sv | 71 +++++++
 rtl/pc_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared redirect-source encoding and sizing helpers for pc_unit and pc_ras.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_CALL,
        SRC_RET
    } redirect_src_e;

    // clog2 of the stack depth, never below 1 so the pointer always has a bit.
    function automatic int ras_ptr_width(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pc_if.sv
// pc_if: fetch-control request / PC response bundle between the fetch stage and pc_unit.
interface pc_if #(parameter int ADDR_WIDTH = 8);

    logic                  en;
    logic                  br_take;
    logic [ADDR_WIDTH-1:0] br_off;
    logic                  jmp_take;
    logic [ADDR_WIDTH-1:0] jmp_addr;
    logic                  call;
    logic                  ret;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  redirect_pending;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  ras_err;

    modport master (
        output en, br_take, br_off, jmp_take, jmp_addr, call, ret,
        input  pc, pc_next, redirect_pending, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  en, br_take, br_off, jmp_take, jmp_addr, call, ret,
        output pc, pc_next, redirect_pending, ras_empty, ras_full, ras_err
    );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; push on a full stack overwrites the oldest entry
// and pop on an empty stack is refused, both raising the sticky err flag.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top_data,
    output logic                  empty,
    output logic                  full,
    output logic                  err
);

    localparam int PTR_W = ras_ptr_width(DEPTH);
    localparam logic [PTR_W:0] COUNT_MAX = (PTR_W+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  err_q, err_d;
    logic [PTR_W-1:0]      top_idx;

    // ptr_q is the next free slot; it wraps naturally because DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        if (pop) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - PTR_W'(1);
                count_d = count_q - (PTR_W+1)'(1);
            end
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            if (count_q == COUNT_MAX) err_d = 1'b1;
            else                      count_d = count_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign top_idx  = ptr_q - PTR_W'(1);
    assign top_data = mem_q[top_idx];
    assign empty    = (count_q == '0);
    assign full     = (count_q == COUNT_MAX);
    assign err      = err_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with branch/jump/call/return redirects held across stalls.
// Define PC_RAS_EN to instantiate the return-address stack; otherwise call acts as jump and ret is ignored.
module pc_unit
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int INC        = 1,
    parameter int RESET_VEC  = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic clk,
    input  logic reset,
    pc_if.slave  bus
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t INC_A   = addr_t'(INC);
    localparam addr_t RESET_A = addr_t'(RESET_VEC);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_unit: RAS_DEPTH must be a power of two and at least 2");
    end

    addr_t         pc_q, pc_d;
    addr_t         pend_q, pend_d;
    logic          pending_q, pending_d;
    addr_t         target;
    addr_t         ras_top;
    logic          redirect;
    redirect_src_e src;

`ifdef PC_RAS_EN
    logic ras_empty;
    logic ras_push;

    assign ras_push = (src == SRC_CALL);

    pc_ras #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (bus.ret),
        .push_data (pc_q + INC_A),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (bus.ras_full),
        .err       (bus.ras_err)
    );

    assign bus.ras_empty = ras_empty;
`else
    logic ras_unused;

    assign ras_unused    = bus.ret;
    assign ras_top       = '0;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_err   = 1'b0;
`endif

    // A ret against an empty stack degrades to sequential and still swallows lower requests.
    always_comb begin
        src = SRC_SEQ;
`ifdef PC_RAS_EN
        if (bus.ret)           src = ras_empty ? SRC_SEQ : SRC_RET;
        else if (bus.call)     src = SRC_CALL;
        else if (bus.jmp_take) src = SRC_JMP;
        else if (bus.br_take)  src = SRC_BR;
`else
        if (bus.call || bus.jmp_take) src = SRC_JMP;
        else if (bus.br_take)         src = SRC_BR;
`endif
    end

    always_comb begin
        target = pc_q + INC_A;
        case (src)
            SRC_BR:   target = pc_q + bus.br_off;
            SRC_JMP:  target = bus.jmp_addr;
            SRC_CALL: target = bus.jmp_addr;
            SRC_RET:  target = ras_top;
            default:  target = pc_q + INC_A;
        endcase
    end

    assign redirect = (src != SRC_SEQ);

    // A live redirect beats a held one; a stalled redirect replaces whatever is held.
    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (bus.en) begin
            pending_d = 1'b0;
            if (redirect)       pc_d = target;
            else if (pending_q) pc_d = pend_q;
            else                pc_d = pc_q + INC_A;
        end else if (redirect) begin
            pend_d    = target;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_A;
            pend_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_next          = pc_d;
    assign bus.redirect_pending = pending_q;

endmodule
